muldiv_sequencer: RTL and testbench

Multi-cycle multiply/divide unit with its own HI/LO register pair, sitting beside the EX-stage ALU of the MIPS pipeline. The decoder issues MULT/MULTU/DIV/DIVU/MTHI/MTLO requests to it. It sequences an iterative shift-add multiplier or restoring divider over WIDTH cycles and holds `busy` so the hazard logic can stall MFHI/MFLO and further mul/div issue. A flush input cancels an in-flight operation on a branch/jump squash.

---
 rtl/muldiv_sequencer.sv | 163 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide unit with private HI/LO registers.
// Shift-add multiply or restoring divide over WIDTH cycles, then one sign-fix cycle.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 div_q, div_d;
  logic                 dbz_q, dbz_d;
  logic                 qsign_q, qsign_d;
  logic                 rsign_q, rsign_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum, mul_upper;
  logic [WIDTH:0]       rem_sh, diff;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quot, rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
      div_q   <= 1'b0;
      dbz_q   <= 1'b0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      dvs_q   <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      div_q   <= div_d;
      dbz_q   <= dbz_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      dvs_q   <= dvs_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    div_d   = div_q;
    dbz_d   = dbz_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    dvs_d   = dvs_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    a_neg = op[0] & a[WIDTH-1];
    b_neg = op[0] & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, dvs_q};
    mul_upper = acc_q[0] ? mul_sum : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    // Remainder can grow to WIDTH+1 bits after the shift, before the trial subtract.
    rem_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff      = rem_sh - {1'b0, dvs_q};

    prod = qsign_q ? -acc_q : acc_q;
    quot = qsign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem  = rsign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      StIdle: begin
        if (start && !flush) begin
          div_d   = op[1];
          dvs_d   = b_mag;
          qsign_d = op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
          rsign_d = op[0] & op[1] & a[WIDTH-1];
          count_d = '0;
          dbz_d   = op[1] && (b == '0);
          if (op[1] && (b == '0)) begin
            // Divide by zero: park the final HI/LO in the accumulator and skip CALC.
            acc_d   = {a, {WIDTH{1'b1}}};
            state_d = StFix;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, a_mag};
            state_d = StCalc;
          end
        end else if (!start) begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      StCalc: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          if (!div_q) begin
            acc_d = {mul_upper, acc_q[WIDTH-1:1]};
          end else if (!diff[WIDTH]) begin
            acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end
          count_d = count_q + CntW'(1);
          if (count_q == CntW'(WIDTH - 1)) state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!flush) begin
          if (dbz_q) begin
            hi_d = acc_q[2*WIDTH-1:WIDTH];
            lo_d = acc_q[WIDTH-1:0];
          end else if (div_q) begin
            hi_d = rem;
            lo_d = quot;
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
          done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: arithmetic reference model checked every cycle,
// plus directed literal checks.
module tb_muldiv_sequencer;

  localparam int unsigned W = 32;

  logic          clk, rst, start, flush, hi_we, lo_we;
  logic [1:0]    op;
  logic [W-1:0]  a, b, wdata;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  int total = 0;
  int bad   = 0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  // Architectural result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] expect_res(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] qv, rv, p;
    if (o[1]) begin
      if (y == 32'd0) return {x, 32'hFFFF_FFFF};
      if (o[0]) begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q  = sx / sy;
        r  = sx % sy;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
      end
      return {x % y, x / y};
    end
    if (o[0]) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      p  = sx * sy;
      return p;
    end
    p = 64'(x) * 64'(y);
    return p;
  endfunction

  // Reference model: cycles left until result, pending result, architectural HI/LO.
  int          m_left;
  logic [63:0] m_res;
  logic [31:0] m_hi, m_lo;
  logic        m_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_res  <= '0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        if (flush) begin
          m_left <= 0;
        end else begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_hi   <= m_res[63:32];
            m_lo   <= m_res[31:0];
            m_done <= 1'b1;
          end
        end
      end else if (start && !flush) begin
        m_left <= (op[1] && b == 32'd0) ? 1 : W + 1;
        m_res  <= expect_res(op, a, b);
      end else if (!start) begin
        if (hi_we) m_hi <= wdata;
        if (lo_we) m_lo <= wdata;
      end
    end
  end

  always @(negedge clk) begin
    cmp("busy", 64'(busy), 64'(m_left > 0));
    cmp("done", 64'(done), 64'(m_done));
    cmp("hi", 64'(hi), 64'(m_hi));
    cmp("lo", 64'(lo), 64'(m_lo));
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int nb, output int nd);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    nb = 0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      nb += int'(busy);
      nd += int'(done);
      tick();
    end
  endtask

  int nb, nd;

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    tick();
    tick();
    rst = 1'b0;
    cmp("reset_busy", 64'(busy), 64'd0);
    cmp("reset_hi", 64'(hi), 64'd0);
    cmp("reset_lo", 64'(lo), 64'd0);

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb, nd);
    cmp("multu_busy_cycles", 64'(nb), 64'd33);
    cmp("multu_done_count", 64'(nd), 64'd1);
    cmp("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    cmp("multu_lo", 64'(lo), 64'h0000_0001);

    run_op(2'b01, 32'hFFFF_FFFD, 32'd5, nb, nd);
    cmp("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    cmp("mult_lo", 64'(lo), 64'hFFFF_FFF1);

    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, nb, nd);
    cmp("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
    cmp("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);

    run_op(2'b11, 32'd7, 32'hFFFF_FFFE, nb, nd);
    cmp("div_negdvs_lo", 64'(lo), 64'hFFFF_FFFD);
    cmp("div_negdvs_hi", 64'(hi), 64'h0000_0001);

    run_op(2'b10, 32'd100, 32'd0, nb, nd);
    cmp("dbz_busy_cycles", 64'(nb), 64'd1);
    cmp("dbz_done_count", 64'(nd), 64'd1);
    cmp("dbz_hi", 64'(hi), 64'h0000_0064);
    cmp("dbz_lo", 64'(lo), 64'hFFFF_FFFF);

    run_op(2'b11, 32'hFFFF_FFF0, 32'd0, nb, nd);
    cmp("sdbz_hi", 64'(hi), 64'hFFFF_FFF0);
    cmp("sdbz_lo", 64'(lo), 64'hFFFF_FFFF);

    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, nb, nd);
    cmp("ovf_lo", 64'(lo), 64'h8000_0000);
    cmp("ovf_hi", 64'(hi), 64'h0000_0000);

    run_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, nb, nd);
    run_op(2'b10, 32'hFFFF_FFFF, 32'd10, nb, nd);
    cmp("divu_lo", 64'(lo), 64'h1999_9999);
    cmp("divu_hi", 64'(hi), 64'h0000_0005);

    // MTHI / MTLO preload, then a flushed MULTU leaves them untouched.
    hi_we = 1'b1; wdata = 32'h1111_1111;
    tick();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h2222_2222;
    tick();
    lo_we = 1'b0;
    cmp("mthi", 64'(hi), 64'h1111_1111);
    cmp("mtlo", 64'(lo), 64'h2222_2222);
    op = 2'b00; a = 32'd7; b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    cmp("flush_busy", 64'(busy), 64'd0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      nd += int'(done);
      tick();
    end
    cmp("flush_no_done", 64'(nd), 64'd0);
    cmp("flush_hi", 64'(hi), 64'h1111_1111);
    cmp("flush_lo", 64'(lo), 64'h2222_2222);

    // Start and MTHI held while busy are both ignored.
    op = 2'b00; a = 32'd3; b = 32'd4; start = 1'b1;
    tick();
    op = 2'b10; a = 32'd50; b = 32'd5; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) begin
        start = 1'b0;
        hi_we = 1'b0;
      end
      nd += int'(done);
      tick();
    end
    cmp("busy_ign_done", 64'(nd), 64'd1);
    cmp("busy_ign_hi", 64'(hi), 64'd0);
    cmp("busy_ign_lo", 64'(lo), 64'd12);

    // Start squashed by a same-cycle flush.
    op = 2'b00; a = 32'd5; b = 32'd5; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    cmp("sq_busy", 64'(busy), 64'd0);
    repeat (3) tick();
    cmp("sq_lo", 64'(lo), 64'd12);

    // Asynchronous reset mid-CALC.
    op = 2'b01; a = 32'hFFFF_FFFD; b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    cmp("rst_busy", 64'(busy), 64'd0);
    cmp("rst_done", 64'(done), 64'd0);
    cmp("rst_hi", 64'(hi), 64'd0);
    cmp("rst_lo", 64'(lo), 64'd0);
    tick();
    rst = 1'b0;
    run_op(2'b10, 32'd1000, 32'd7, nb, nd);
    cmp("post_rst_done", 64'(nd), 64'd1);
    cmp("post_rst_lo", 64'(lo), 64'd142);
    cmp("post_rst_hi", 64'(hi), 64'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
